// File: rtl/chunked_add_sub_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : chunked_add_sub_if                                              |
// | Brief  : Operand/result valid-ready bus for the chunked adder/subtractor |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface chunked_add_sub_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/chunked_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : chunked_add_sub                                                 |
// | Brief  : Multi-cycle add/sub, CHUNK bits per clock, valid/ready on both  |
// |          sides. Define CHUNKED_ADD_SUB_SAT_EN to clamp s on overflow.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    chunked_add_sub_if.slave  bus
);
    localparam int                c_ncyc = WIDTH / CHUNK;
    localparam int                c_cntw = (c_ncyc > 1) ? $clog2(c_ncyc) : 1;
    localparam logic [c_cntw-1:0] c_last = c_cntw'(c_ncyc - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic              r_carry;
    logic [c_cntw-1:0] r_cnt;
    logic [WIDTH-1:0]  r_s;
    logic              r_cout;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;

    logic [CHUNK:0]    w_sum;
    logic [WIDTH-1:0]  w_res;
    logic [WIDTH-1:0]  w_res_out;
    logic              w_ovf;

    assign w_sum = {1'b0, r_x[CHUNK-1:0]} + {1'b0, r_y[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};

    // On the last chunk r_x/r_y low slices hold the operand sign bits
    // (y already inverted for subtraction).
    assign w_ovf = (r_x[CHUNK-1] == r_y[CHUNK-1]) && (w_sum[CHUNK-1] != r_x[CHUNK-1]);

    // Earlier chunks enter from the MSB side and migrate down as new ones arrive.
    generate
        if (CHUNK < WIDTH) begin : g_acc
            logic [WIDTH-CHUNK-1:0] r_acc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == S_RUN) begin
                    r_acc <= w_res[WIDTH-1:CHUNK];
                end
            end

            assign w_res = {w_sum[CHUNK-1:0], r_acc};
        end else begin : g_full
            assign w_res = w_sum[CHUNK-1:0];
        end
    endgenerate

`ifdef CHUNKED_ADD_SUB_SAT_EN
    assign w_res_out = !w_ovf         ? w_res :
                       r_x[CHUNK-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                        {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_res_out = w_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x        <= bus.x;
                        r_y        <= bus.y ^ {WIDTH{bus.sub}};
                        r_carry    <= bus.sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x     <= r_x >> CHUNK;
                    r_y     <= r_y >> CHUNK;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_s         <= w_res_out;
                        r_cout      <= w_sum[CHUNK];
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_chunked_add_sub                                              |
// | Brief  : Directed bench for chunked_add_sub at CHUNK = 1, 4 and 16       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_chunked_add_sub;
`ifdef CHUNKED_ADD_SUB_SAT_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    chunked_add_sub_if #(.WIDTH(16)) if1  ();
    chunked_add_sub_if #(.WIDTH(16)) if4  ();
    chunked_add_sub_if #(.WIDTH(16)) if16 ();

    chunked_add_sub #(.WIDTH(16), .CHUNK(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
    chunked_add_sub #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single operation on the CHUNK=4 instance, out_ready held high.
    task automatic do_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                         input logic sv, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        chk({tag, ":in_ready"}, 32'(if4.in_ready), 32'd1);
        if4.x = xv; if4.y = yv; if4.sub = sv; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        if4.x = 16'hA5A5; if4.y = 16'h5A5A; if4.sub = ~sv;
        n = 0;
        while (!if4.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'd4);
        chk({tag, ":s"},       32'(if4.s),    32'(es));
        chk({tag, ":cout"},    32'(if4.cout), 32'(ec));
        chk({tag, ":ovf"},     32'(if4.ovf),  32'(eo));
        tick();
        chk({tag, ":idle"},    32'({if4.in_ready, if4.out_valid}), 32'b10);
    endtask

    // Same operation issued to all three chunk widths, checked against a full-width model.
    task automatic sweep_op(input logic [15:0] xv, input logic [15:0] yv, input logic sv);
        logic [16:0] full;
        logic [15:0] yi;
        logic [15:0] es;
        logic        eo;
        int l1, l4, l16;
        logic [17:0] r1, r4, r16;
        yi   = yv ^ {16{sv}};
        full = {1'b0, xv} + {1'b0, yi} + 17'(sv);
        eo   = (xv[15] == yi[15]) && (full[15] != xv[15]);
        es   = full[15:0];
        if (c_sat && eo) es = xv[15] ? 16'h8000 : 16'h7FFF;
        l1 = 0; l4 = 0; l16 = 0; r1 = '0; r4 = '0; r16 = '0;
        chk("sweep:ready", 32'({if1.in_ready, if4.in_ready, if16.in_ready}), 32'b111);
        if1.x = xv;  if1.y = yv;  if1.sub = sv;  if1.in_valid = 1'b1;
        if4.x = xv;  if4.y = yv;  if4.sub = sv;  if4.in_valid = 1'b1;
        if16.x = xv; if16.y = yv; if16.sub = sv; if16.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0; if4.in_valid = 1'b0; if16.in_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (l1 == 0 && if1.out_valid) begin
                l1 = k; r1 = {if1.s, if1.cout, if1.ovf};
            end
            if (l4 == 0 && if4.out_valid) begin
                l4 = k; r4 = {if4.s, if4.cout, if4.ovf};
            end
            if (l16 == 0 && if16.out_valid) begin
                l16 = k; r16 = {if16.s, if16.cout, if16.ovf};
            end
            tick();
        end
        // Loop samples before each edge, so a result valid after edge E+n is seen at k = n+1.
        chk("sweep:lat_c1",  32'(l1),  32'd17);
        chk("sweep:lat_c4",  32'(l4),  32'd5);
        chk("sweep:lat_c16", 32'(l16), 32'd2);
        chk("sweep:res_c1",  32'(r1),  32'({es, full[16], eo}));
        chk("sweep:res_c4",  32'(r4),  32'({es, full[16], eo}));
        chk("sweep:res_c16", 32'(r16), 32'({es, full[16], eo}));
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        if1.in_valid = 1'b0;  if1.x = '0;  if1.y = '0;  if1.sub = 1'b0;  if1.out_ready = 1'b1;
        if4.in_valid = 1'b0;  if4.x = '0;  if4.y = '0;  if4.sub = 1'b0;  if4.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.x = '0; if16.y = '0; if16.sub = 1'b0; if16.out_ready = 1'b1;
        repeat (3) tick();
        chk("reset:in_ready",  32'(if4.in_ready),  32'd1);
        chk("reset:out_valid", 32'(if4.out_valid), 32'd0);
        chk("reset:s_cout_ovf", 32'({if4.s, if4.cout, if4.ovf}), 32'd0);
        rst = 1'b0;
        tick();

        do_op("add_3_5",   16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_op("sub_7_9",   16'h0007, 16'h0009, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_9_7",   16'h0009, 16'h0007, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, c_sat ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
        do_op("neg_ovf",   16'h8000, 16'h0001, 1'b1, c_sat ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
        do_op("wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_8000",  16'h8000, 16'h8000, 1'b0, 16'h0000 | (c_sat ? 16'h8000 : 16'h0000), 1'b1, 1'b1);
        do_op("sub_0_0",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op("add_mixed", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Backpressure: result held while out_ready is low, new operands refused.
        if4.out_ready = 1'b0;
        if4.x = 16'h1111; if4.y = 16'h2222; if4.sub = 1'b0; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp:latency", 32'(n), 32'd4);
        if4.x = 16'h0005; if4.y = 16'h0006; if4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp:hold_result", 32'({if4.s, if4.cout, if4.ovf}), 32'({16'h3333, 2'b00}));
            chk("bp:hold_flags",  32'({if4.out_valid, if4.in_ready}), 32'b10);
            tick();
        end
        if4.out_ready = 1'b1;
        tick();
        chk("bp:released", 32'({if4.in_ready, if4.out_valid}), 32'b10);
        tick();
        if4.in_valid = 1'b0;
        chk("bp:accepted", 32'(if4.in_ready), 32'd0);
        n = 0;
        while (!if4.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp:next_latency", 32'(n), 32'd4);
        chk("bp:next_s",       32'(if4.s), 32'h000B);
        tick();

        // Reset during the second RUN cycle.
        if4.x = 16'h00FF; if4.y = 16'h0001; if4.sub = 1'b0; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid:flags", 32'({if4.in_ready, if4.out_valid}), 32'b10);
        chk("rst_mid:s",     32'(if4.s), 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        chk("rst_mid:no_output", 32'(if4.out_valid), 32'd0);
        do_op("rst_mid:after", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Chunk-width sweep: directed corners plus random vectors.
        sweep_op(16'h7FFF, 16'h0001, 1'b0);
        sweep_op(16'h8000, 16'h0001, 1'b1);
        sweep_op(16'hBEEF, 16'h4111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            sweep_op(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
